// File: rtl/reg_file_banked.sv
// reg_file_banked: parametrised register file with two combinational read
// ports, a pair-equality flag, three write sources (data, immediate, move)
// and a shadow bank. A sequenced engine copies the main bank to the shadow
// bank (save) or back (restore), one register per cycle, under a
// request/busy/done handshake.
//
// Optional feature: define REG_FILE_BYPASS_EN to forward the value being
// written this cycle to any read port whose address matches the write
// address. Forwarding is active only while the engine is idle.
module reg_file_banked #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int IW    = 6
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          WriteEn,
    input  logic [1:0]    WrMode,
    input  logic [AW-1:0] Waddr,
    input  logic [W-1:0]  DataIn,
    input  logic [IW-1:0] ImmVal,
    input  logic [AW-1:0] MoveFrom,
    input  logic [AW-1:0] RaddrA,
    input  logic [AW-1:0] RaddrB,
    output logic [W-1:0]  DataOutA,
    output logic [W-1:0]  DataOutB,
    output logic          Eq,
    input  logic          SaveReq,
    input  logic          RestoreReq,
    output logic          Busy,
    output logic          Done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_RESTORE = 2'd2
    } state_t;

    localparam logic [1:0]    MODE_DATA = 2'b00;
    localparam logic [1:0]    MODE_IMM  = 2'b01;
    localparam logic [1:0]    MODE_MOVE = 2'b10;
    localparam logic [AW-1:0] CNT_LAST  = AW'(DEPTH - 1);

    logic [W-1:0]  main_q   [DEPTH];
    logic [W-1:0]  main_d   [DEPTH];
    logic [W-1:0]  shadow_q [DEPTH];
    logic [W-1:0]  shadow_d [DEPTH];
    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    logic [W-1:0]  wr_val;
    logic          wr_fire;
    logic [W-1:0]  rd_a, rd_b;

    // Select the write source; a reserved mode never fires, so its value is irrelevant.
    always_comb begin
        wr_val = '0;
        case (WrMode)
            MODE_DATA: wr_val = DataIn;
            MODE_IMM:  wr_val[IW-1:0] = ImmVal;
            MODE_MOVE: wr_val = main_q[MoveFrom];
            default:   wr_val = '0;
        endcase
        wr_fire = (state_q == ST_IDLE) && WriteEn && (WrMode != 2'b11);
    end

    // Next-state, copy engine and main-bank write logic.
    always_comb begin
        main_d   = main_q;
        shadow_d = shadow_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_fire) begin
                    main_d[Waddr] = wr_val;
                end
                // Save has priority; a simultaneous restore request is dropped.
                if (SaveReq) begin
                    state_d = ST_SAVE;
                    cnt_d   = '0;
                end else if (RestoreReq) begin
                    state_d = ST_RESTORE;
                    cnt_d   = '0;
                end
            end
            ST_SAVE, ST_RESTORE: begin
                if (state_q == ST_SAVE) begin
                    shadow_d[cnt_q] = main_q[cnt_q];
                end else begin
                    main_d[cnt_q] = shadow_q[cnt_q];
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Control registers: engine state, copy counter and the registered done pulse.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // One register pair (main + shadow) per entry; both banks clear on reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        // Per-entry storage update for both banks.
        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                main_q[gi]   <= '0;
                shadow_q[gi] <= '0;
            end else begin
                main_q[gi]   <= main_d[gi];
                shadow_q[gi] <= shadow_d[gi];
            end
        end
    end

    // Read ports: stored contents, optionally overridden by the in-flight write.
    always_comb begin
        rd_a = main_q[RaddrA];
        rd_b = main_q[RaddrB];
`ifdef REG_FILE_BYPASS_EN
        if (wr_fire && (RaddrA == Waddr)) begin
            rd_a = wr_val;
        end
        if (wr_fire && (RaddrB == Waddr)) begin
            rd_b = wr_val;
        end
`endif
    end

    assign DataOutA = rd_a;
    assign DataOutB = rd_b;
    assign Eq       = (rd_a == rd_b);
    assign Busy     = (state_q != ST_IDLE);
    assign Done     = done_q;

endmodule

// File: tb/tb_reg_file_banked.sv
// tb_reg_file_banked: directed plus randomized checks of reg_file_banked
// against a plain-array reference of the main and shadow banks.
module tb_reg_file_banked;

    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int IW    = 6;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          WriteEn;
    logic [1:0]    WrMode;
    logic [AW-1:0] Waddr;
    logic [W-1:0]  DataIn;
    logic [IW-1:0] ImmVal;
    logic [AW-1:0] MoveFrom;
    logic [AW-1:0] RaddrA;
    logic [AW-1:0] RaddrB;
    logic [W-1:0]  DataOutA;
    logic [W-1:0]  DataOutB;
    logic          Eq;
    logic          SaveReq;
    logic          RestoreReq;
    logic          Busy;
    logic          Done;

    int vectors    = 0;
    int miscompares = 0;

    logic [W-1:0] ref_main   [DEPTH];
    logic [W-1:0] ref_shadow [DEPTH];

    reg_file_banked #(.W(W), .DEPTH(DEPTH), .IW(IW)) dut (
        .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .WrMode(WrMode),
        .Waddr(Waddr), .DataIn(DataIn), .ImmVal(ImmVal), .MoveFrom(MoveFrom),
        .RaddrA(RaddrA), .RaddrB(RaddrB), .DataOutA(DataOutA), .DataOutB(DataOutB),
        .Eq(Eq), .SaveReq(SaveReq), .RestoreReq(RestoreReq), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_model();
        foreach (ref_main[i]) begin
            ref_main[i]   = '0;
            ref_shadow[i] = '0;
        end
    endtask

    // Sweep every register through both ports while idle.
    task automatic check_all();
        WriteEn = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            RaddrA = AW'(i);
            RaddrB = AW'(DEPTH - 1 - i);
            @(negedge Clk);
            chk("sweep_a", DataOutA, ref_main[i]);
            chk("sweep_b", DataOutB, ref_main[DEPTH - 1 - i]);
            chk("sweep_eq", W'(Eq), W'(ref_main[i] == ref_main[DEPTH - 1 - i]));
        end
        tick();
    endtask

    // One write cycle: checks reads before the edge (forwarding) and after.
    task automatic do_write(input logic en, input logic [1:0] mode, input logic [AW-1:0] wa,
                            input logic [W-1:0] din, input logic [IW-1:0] imm,
                            input logic [AW-1:0] mf, input logic [AW-1:0] ra,
                            input logic [AW-1:0] rb);
        logic [W-1:0] wv;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic         fire;
        WriteEn = en; WrMode = mode; Waddr = wa; DataIn = din;
        ImmVal = imm; MoveFrom = mf; RaddrA = ra; RaddrB = rb;
        fire = en && (mode != 2'b11);
        case (mode)
            2'b00:   wv = din;
            2'b01:   wv = {2'b00, imm};
            2'b10:   wv = ref_main[mf];
            default: wv = '0;
        endcase
        ea = ref_main[ra];
        eb = ref_main[rb];
`ifdef REG_FILE_BYPASS_EN
        if (fire && ra == wa) ea = wv;
        if (fire && rb == wa) eb = wv;
`endif
        #1;
        chk("pre_a", DataOutA, ea);
        chk("pre_b", DataOutB, eb);
        chk("pre_eq", W'(Eq), W'(ea == eb));
        tick();
        WriteEn = 1'b0;
        if (fire) ref_main[wa] = wv;
        #1;
        chk("post_a", DataOutA, ref_main[ra]);
        chk("post_b", DataOutB, ref_main[rb]);
        chk("post_eq", W'(Eq), W'(ref_main[ra] == ref_main[rb]));
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++)
            do_write(1'b1, 2'b00, AW'(i), W'($urandom), '0, '0, AW'(i), AW'($urandom_range(0, DEPTH - 1)));
    endtask

    task automatic start_seq(input logic s, input logic r);
        SaveReq = s;
        RestoreReq = r;
        tick();
        SaveReq = 1'b0;
        RestoreReq = 1'b0;
    endtask

    // Runs the DEPTH busy cycles after acceptance; returns in the Done cycle.
    task automatic seq_body(input bit is_restore, input bit try_write);
        for (int c = 0; c < DEPTH; c++) begin
            logic [AW-1:0] idx;
            logic [W-1:0]  e;
            chk("busy_hi", W'(Busy), W'(1));
            chk("done_lo", W'(Done), W'(0));
            idx = (c == 3) ? AW'(4) : AW'($urandom_range(0, DEPTH - 1));
            RaddrA = idx;
            if (try_write && c == 3) begin
                WriteEn = 1'b1; WrMode = 2'b00; Waddr = AW'(4); DataIn = 8'h55;
            end else begin
                WriteEn = 1'b0;
            end
            e = (is_restore && int'(idx) < c) ? ref_shadow[idx] : ref_main[idx];
            #1;
            chk("busy_rd", DataOutA, e);
            tick();
        end
        WriteEn = 1'b0;
        if (is_restore) ref_main = ref_shadow;
        else ref_shadow = ref_main;
        chk("end_busy", W'(Busy), W'(0));
        chk("end_done", W'(Done), W'(1));
    endtask

    initial begin
        Reset = 1'b1; WriteEn = 1'b0; WrMode = 2'b00; Waddr = '0; DataIn = '0;
        ImmVal = '0; MoveFrom = '0; RaddrA = '0; RaddrB = '0; SaveReq = 1'b0; RestoreReq = 1'b0;
        clear_model();
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_a", DataOutA, '0);
        chk("rst_b", DataOutB, '0);
        chk("rst_eq", W'(Eq), W'(1));
        chk("rst_busy", W'(Busy), W'(0));
        chk("rst_done", W'(Done), W'(0));
        Reset = 1'b0;
        tick();

        // Asynchronous reset clears a written register immediately.
        do_write(1'b1, 2'b00, AW'(3), 8'hA5, '0, '0, AW'(3), AW'(0));
        #2 Reset = 1'b1;
        #1;
        chk("arst_a", DataOutA, '0);
        chk("arst_eq", W'(Eq), W'(1));
        chk("arst_busy", W'(Busy), W'(0));
        chk("arst_done", W'(Done), W'(0));
        clear_model();
        tick();
        Reset = 1'b0;
        tick();

        // Directed write modes.
        do_write(1'b1, 2'b01, AW'(2), '0, 6'h3F, '0, AW'(2), AW'(0));
        chk("imm_val", DataOutA, 8'h3F);
        do_write(1'b1, 2'b10, AW'(7), '0, '0, AW'(2), AW'(2), AW'(7));
        chk("move_val", DataOutB, 8'h3F);
        chk("eq_pair", W'(Eq), W'(1));
        do_write(1'b1, 2'b11, AW'(2), 8'h12, 6'h05, AW'(0), AW'(2), AW'(7));
        check_all();

        // Same-cycle forwarding behaviour on a data write.
        do_write(1'b1, 2'b00, AW'(1), 8'h9C, '0, '0, AW'(1), AW'(2));

        // Randomized writes across all modes.
        for (int n = 0; n < 150; n++) begin
            logic [AW-1:0] wa;
            wa = AW'($urandom_range(0, DEPTH - 1));
            do_write(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), wa, W'($urandom),
                     IW'($urandom), AW'($urandom_range(0, DEPTH - 1)),
                     ($urandom_range(0, 1) != 0) ? wa : AW'($urandom_range(0, DEPTH - 1)),
                     AW'($urandom_range(0, DEPTH - 1)));
        end
        check_all();

        // Save i+0x10 with a lost write attempt mid-sequence.
        for (int i = 0; i < DEPTH; i++)
            do_write(1'b1, 2'b00, AW'(i), W'(i + 8'h10), '0, '0, AW'(i), AW'(0));
        start_seq(1'b1, 1'b0);
        seq_body(1'b0, 1'b1);
        tick();
        chk("save_done_pulse", W'(Done), W'(0));
        check_all();

        // Overwrite with 0xFF, then restore.
        for (int i = 0; i < DEPTH; i++)
            do_write(1'b1, 2'b00, AW'(i), 8'hFF, '0, '0, AW'(i), AW'(0));
        start_seq(1'b0, 1'b1);
        seq_body(1'b1, 1'b0);
        tick();
        chk("rest_done_pulse", W'(Done), W'(0));
        check_all();

        // Simultaneous requests: save wins, main unchanged.
        fill_random();
        start_seq(1'b1, 1'b1);
        seq_body(1'b0, 1'b0);
        tick();
        check_all();

        // Restore followed back-to-back by a save requested in the Done cycle.
        fill_random();
        start_seq(1'b0, 1'b1);
        seq_body(1'b1, 1'b0);
        start_seq(1'b1, 1'b0);
        seq_body(1'b0, 1'b0);
        tick();
        check_all();

        // Reset at copy cycle 5 of a save aborts it and clears the shadow bank.
        fill_random();
        start_seq(1'b1, 1'b0);
        repeat (5) tick();
        #2 Reset = 1'b1;
        #1;
        chk("abort_busy", W'(Busy), W'(0));
        chk("abort_done", W'(Done), W'(0));
        clear_model();
        tick();
        Reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_no_done", W'(Done), W'(0));
        end
        fill_random();
        start_seq(1'b0, 1'b1);
        seq_body(1'b1, 1'b0);
        tick();
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
